// File: rtl/ac_setpoint_ctrl.sv
// AC setpoint controller: BCD setpoint with saturating up/down, timed sleep FSM, three 7-seg digits.
// Optional macro AUTOREPEAT_EN adds hold-to-repeat on the up/down buttons.
module ac_setpoint_ctrl #(
  parameter int TICK_DIV   = 50000000,
  parameter int TEMP_MIN   = 16,
  parameter int TEMP_MAX   = 30,
  parameter int TEMP_INIT  = 22,
  parameter int REPEAT_DLY = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pwr_sw,
  input  logic       btn_up,
  input  logic       btn_dn,
  input  logic       btn_sleep,
  output logic [3:0] set_tens,
  output logic [3:0] set_ones,
  output logic [7:0] hex_hi,
  output logic [7:0] hex_lo,
  output logic [7:0] hex_tmr,
  output logic       pwr_led,
  output logic       sleep_active,
  output logic       sleep_done
);

  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [7:0] MAX_BCD  = {4'(TEMP_MAX / 10), 4'(TEMP_MAX % 10)};
  localparam logic [7:0] MIN_BCD  = {4'(TEMP_MIN / 10), 4'(TEMP_MIN % 10)};
  localparam logic [7:0] INIT_BCD = {4'(TEMP_INIT / 10), 4'(TEMP_INIT % 10)};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [3:0]    s1_q, s2_q;
  logic [2:0]    prev_q;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [7:0]    set_q, set_d;
  logic [2:0]    step_q, step_d;
  logic [7:0]    hex_hi_q, hex_hi_d, hex_lo_q, hex_lo_d, hex_tmr_q, hex_tmr_d;
  logic          pwr_led_q;

  logic pwr_s, up_lvl, dn_lvl, slp_lvl;
  logic up_e, dn_e, slp_e, tick;
  logic rep_up, rep_dn, do_up, do_dn;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'hC0;
      4'd1:    seg7 = 8'hF9;
      4'd2:    seg7 = 8'hA4;
      4'd3:    seg7 = 8'hB0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hF8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  // Packed BCD preserves numeric order, so plain compares implement the saturation limits.
  function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic up);
    if (up) begin
      if (v >= MAX_BCD)        bcd_step = v;
      else if (v[3:0] == 4'd9) bcd_step = {v[7:4] + 4'd1, 4'd0};
      else                     bcd_step = {v[7:4], v[3:0] + 4'd1};
    end else begin
      if (v <= MIN_BCD)        bcd_step = v;
      else if (v[3:0] == 4'd0) bcd_step = {v[7:4] - 4'd1, 4'd9};
      else                     bcd_step = {v[7:4], v[3:0] - 4'd1};
    end
  endfunction

  assign pwr_s   = s2_q[3];
  assign up_lvl  = s2_q[2];
  assign dn_lvl  = s2_q[1];
  assign slp_lvl = s2_q[0];
  assign up_e    = up_lvl  & ~prev_q[2];
  assign dn_e    = dn_lvl  & ~prev_q[1];
  assign slp_e   = slp_lvl & ~prev_q[0];
  assign tick    = (tick_cnt_q == TICK_LAST);
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

`ifdef AUTOREPEAT_EN
  localparam int HW = (REPEAT_DLY > 0) ? $clog2(REPEAT_DLY + 1) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(REPEAT_DLY);
  logic [HW-1:0] hold_up_q, hold_up_d, hold_dn_q, hold_dn_d;

  always_comb begin
    hold_up_d = hold_up_q;
    hold_dn_d = hold_dn_q;
    if (!up_lvl)                              hold_up_d = '0;
    else if (tick && hold_up_q < HOLD_LAST)   hold_up_d = hold_up_q + 1'b1;
    if (!dn_lvl)                              hold_dn_d = '0;
    else if (tick && hold_dn_q < HOLD_LAST)   hold_dn_d = hold_dn_q + 1'b1;
  end

  assign rep_up = tick & up_lvl & ~dn_lvl & (hold_up_q == HOLD_LAST);
  assign rep_dn = tick & dn_lvl & ~up_lvl & (hold_dn_q == HOLD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_up_q <= '0;
      hold_dn_q <= '0;
    end else begin
      hold_up_q <= hold_up_d;
      hold_dn_q <= hold_dn_d;
    end
  end
`else
  assign rep_up = 1'b0;
  assign rep_dn = 1'b0;
`endif

  assign do_up = pwr_s && (state_q != RUN) && ((up_e && !dn_e) || rep_up);
  assign do_dn = pwr_s && (state_q != RUN) && ((dn_e && !up_e) || rep_dn);

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    set_d   = set_q;
    if (do_up)      set_d = bcd_step(set_q, 1'b1);
    else if (do_dn) set_d = bcd_step(set_q, 1'b0);
    case (state_q)
      IDLE: begin
        if (pwr_s && slp_e) begin
          state_d = RUN;
          step_d  = 3'd0;
        end
      end
      RUN: begin
        if (!pwr_s || slp_e) begin
          state_d = IDLE;
        end else if (tick) begin
          step_d = step_q + 3'd1;
          case (step_d)
            3'd1, 3'd2: set_d = bcd_step(set_q, 1'b1);
            3'd5:       set_d = bcd_step(set_q, 1'b0);
            3'd7:       state_d = DONE;
            default:    ;
          endcase
        end
      end
      DONE: begin
        if (!pwr_s || slp_e) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Display path reads registered state so digits trail the setpoint by one cycle.
  always_comb begin
    hex_hi_d  = 8'hFF;
    hex_lo_d  = 8'hFF;
    hex_tmr_d = 8'hFF;
    if (pwr_s) begin
      if (state_q == DONE) begin
        hex_hi_d  = 8'h80;
        hex_lo_d  = 8'h80;
        hex_tmr_d = seg7(4'd7);
      end else begin
        hex_hi_d = seg7(set_q[7:4]);
        hex_lo_d = seg7(set_q[3:0]);
        if (state_q == RUN) hex_tmr_d = seg7({1'b0, step_q});
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q       <= '0;
      s2_q       <= '0;
      prev_q     <= '0;
      tick_cnt_q <= '0;
      state_q    <= IDLE;
      set_q      <= INIT_BCD;
      step_q     <= '0;
      hex_hi_q   <= 8'hFF;
      hex_lo_q   <= 8'hFF;
      hex_tmr_q  <= 8'hFF;
      pwr_led_q  <= 1'b0;
    end else begin
      s1_q       <= {pwr_sw, btn_up, btn_dn, btn_sleep};
      s2_q       <= s1_q;
      prev_q     <= {up_lvl, dn_lvl, slp_lvl};
      tick_cnt_q <= tick_cnt_d;
      state_q    <= state_d;
      set_q      <= set_d;
      step_q     <= step_d;
      hex_hi_q   <= hex_hi_d;
      hex_lo_q   <= hex_lo_d;
      hex_tmr_q  <= hex_tmr_d;
      pwr_led_q  <= pwr_s;
    end
  end

  assign set_tens     = set_q[7:4];
  assign set_ones     = set_q[3:0];
  assign hex_hi       = hex_hi_q;
  assign hex_lo       = hex_lo_q;
  assign hex_tmr      = hex_tmr_q;
  assign pwr_led      = pwr_led_q;
  assign sleep_active = (state_q == RUN);
  assign sleep_done   = (state_q == DONE);

endmodule

// File: tb/tb_ac_setpoint_ctrl.sv
// Bench for ac_setpoint_ctrl with TICK_DIV=4, REPEAT_DLY=2; compile with AUTOREPEAT_EN to exercise repeat.
module tb_ac_setpoint_ctrl;
  localparam int TD = 4;
  localparam int RD = 2;

  logic clk = 1'b0, rst = 1'b1, pwr_sw = 1'b0;
  logic btn_up = 1'b0, btn_dn = 1'b0, btn_sleep = 1'b0;
  logic [3:0] set_tens, set_ones;
  logic [7:0] hex_hi, hex_lo, hex_tmr;
  logic pwr_led, sleep_active, sleep_done;

  ac_setpoint_ctrl #(.TICK_DIV(TD), .TEMP_MIN(16), .TEMP_MAX(30), .TEMP_INIT(22), .REPEAT_DLY(RD)) dut (
    .clk(clk), .rst(rst), .pwr_sw(pwr_sw), .btn_up(btn_up), .btn_dn(btn_dn), .btn_sleep(btn_sleep),
    .set_tens(set_tens), .set_ones(set_ones), .hex_hi(hex_hi), .hex_lo(hex_lo), .hex_tmr(hex_tmr),
    .pwr_led(pwr_led), .sleep_active(sleep_active), .sleep_done(sleep_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic up;
    logic dn;
    int   exp;
  } vec_t;

  int   n_vec = 0;
  int   n_bad = 0;
  int   exp_q[$];
  vec_t tbl[$];

  function automatic logic [7:0] seg(input int d);
    case (d)
      0: seg = 8'hC0;  1: seg = 8'hF9;  2: seg = 8'hA4;  3: seg = 8'hB0;  4: seg = 8'h99;
      5: seg = 8'h92;  6: seg = 8'h82;  7: seg = 8'hF8;  8: seg = 8'h80;  9: seg = 8'h90;
      default: seg = 8'hFF;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_temp(input string nm);
    int t;
    t = exp_q.pop_front();
    chk(nm, {8'h0, set_tens, set_ones, hex_hi, hex_lo},
        {8'h0, 4'(t / 10), 4'(t % 10), seg(t / 10), seg(t % 10)});
  endtask

  task automatic press(input logic u, input logic d);
    @(negedge clk);
    btn_up = u; btn_dn = d;
    @(negedge clk);
    btn_up = 1'b0; btn_dn = 1'b0;
    cyc(5);
  endtask

  task automatic pulse_sleep();
    @(negedge clk);
    btn_sleep = 1'b1;
    @(negedge clk);
    btn_sleep = 1'b0;
  endtask

  task automatic wait_tmr(input logic [7:0] want, input string nm);
    int k;
    k = 0;
    while (hex_tmr !== want && k < 16) begin
      @(negedge clk);
      k++;
    end
    chk(nm, {24'h0, hex_tmr}, {24'h0, want});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(6);
  endtask

  // Reference model of the up-button path: 2-FF sync, edge detect, free-running tick, hold counter.
  int m_s1, m_s2, m_prev, m_cnt, m_hold, m_temp;
  always @(posedge clk) begin
    bit m_tick, m_edge, m_rep;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_prev = 0; m_cnt = 0; m_hold = 0; m_temp = 22;
    end else begin
      m_tick = (m_cnt == TD - 1);
      m_edge = (m_s2 == 1) && (m_prev == 0);
`ifdef AUTOREPEAT_EN
      m_rep = m_tick && (m_s2 == 1) && (m_hold == RD);
`else
      m_rep = 1'b0;
`endif
      if (m_s2 == 0) m_hold = 0;
      else if (m_tick && m_hold < RD) m_hold++;
      if ((m_edge || m_rep) && m_temp < 30) m_temp++;
      m_prev = m_s2;
      m_s2 = m_s1;
      m_s1 = int'(btn_up);
      m_cnt = m_tick ? 0 : m_cnt + 1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t;
    int sleep_exp[7];
    t = 22;
    for (int i = 0; i < 9; i++)  begin t = (t < 30) ? t + 1 : t; tbl.push_back('{1'b1, 1'b0, t}); end
    for (int i = 0; i < 15; i++) begin t = (t > 16) ? t - 1 : t; tbl.push_back('{1'b0, 1'b1, t}); end
    for (int i = 0; i < 4; i++)  begin t = (t < 30) ? t + 1 : t; tbl.push_back('{1'b1, 1'b0, t}); end
    tbl.push_back('{1'b1, 1'b1, t});
    sleep_exp = '{22, 23, 24, 24, 24, 23, 23};

    // Reset state with power off, then power on.
    cyc(2);
    chk("reset_outputs", {16'h0, 2'b00, set_tens, set_ones, hex_hi},
        {16'h0, 2'b00, 4'd2, 4'd2, 8'hFF});
    chk("reset_flags", {5'h0, pwr_led, sleep_active, sleep_done, hex_lo, hex_tmr},
        {5'h0, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF});
    rst = 1'b0;
    pwr_sw = 1'b1;
    cyc(5);
    chk("power_on", {set_tens, set_ones, hex_hi, hex_lo, hex_tmr, 7'h0, pwr_led},
        {4'd2, 4'd2, 8'hA4, 8'hA4, 8'hFF, 7'h0, 1'b1});

    // Saturation, BCD wrap and simultaneous buttons.
    foreach (tbl[i]) begin
      press(tbl[i].up, tbl[i].dn);
      exp_q.push_back(tbl[i].exp);
      check_temp($sformatf("vec%0d", i));
    end

    // Hold up: per-cycle trace against the model.
    do_reset();
    @(negedge clk);
    btn_up = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("hold_c%0d", i), {24'h0, set_tens, set_ones},
          {24'h0, 4'(m_temp / 10), 4'(m_temp % 10)});
    end
    btn_up = 1'b0;
    cyc(6);
    exp_q.push_back(m_temp);
    check_temp("hold_final");

    // Full sleep sequence.
    do_reset();
    pulse_sleep();
    for (int k = 0; k < 7; k++) begin
      wait_tmr(seg(k), $sformatf("sleep_step%0d", k));
      exp_q.push_back(sleep_exp[k]);
      check_temp($sformatf("sleep_temp%0d", k));
    end
    chk("sleep_active", {31'h0, sleep_active}, 32'h1);
    wait_tmr(8'hF8, "done_tmr");
    cyc(1);
    chk("done_disp", {sleep_done, 7'h0, set_tens, set_ones, hex_hi, hex_lo},
        {1'b1, 7'h0, 4'd2, 4'd3, 8'h80, 8'h80});
    pulse_sleep();
    cyc(5);
    chk("done_exit", {6'h0, sleep_done, sleep_active, 16'h0, hex_tmr}, {6'h0, 1'b0, 1'b0, 16'h0, 8'hFF});
    exp_q.push_back(23);
    check_temp("done_exit_temp");

    // Cancel at step 3.
    do_reset();
    pulse_sleep();
    wait_tmr(seg(3), "cancel_step3");
    pulse_sleep();
    cyc(5);
    chk("cancel_state", {7'h0, sleep_active, 16'h0, hex_tmr}, {7'h0, 1'b0, 16'h0, 8'hFF});
    exp_q.push_back(24);
    check_temp("cancel_temp");

    // Power drop during RUN, button ignored while off.
    pulse_sleep();
    wait_tmr(seg(3), "pwr_run_step3");
    pwr_sw = 1'b0;
    cyc(5);
    chk("pwr_off", {6'h0, sleep_active, pwr_led, hex_hi, hex_lo, hex_tmr},
        {6'h0, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF});
    press(1'b1, 1'b0);
    pwr_sw = 1'b1;
    cyc(5);
    exp_q.push_back(26);
    check_temp("pwr_restore_temp");
    chk("pwr_restore_idle", {31'h0, sleep_active}, 32'h0);

    // Reset asserted mid-run.
    pulse_sleep();
    wait_tmr(seg(2), "midrun_step2");
    rst = 1'b1;
    @(negedge clk);
    chk("midrun_reset", {set_tens, set_ones, hex_hi, hex_lo},
        {4'd2, 4'd2, 8'hFF, 8'hFF});
    chk("midrun_flags", {5'h0, pwr_led, sleep_active, sleep_done, 16'h0, hex_tmr},
        {5'h0, 1'b0, 1'b0, 1'b0, 16'h0, 8'hFF});
    rst = 1'b0;
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
